mux4_rr_scheduler: RTL and testbench

//   Round-robin scheduler that shares one 4:1 selector among four requesters.

---
 rtl/mux4_rr_scheduler.sv | 112 +++++++++++
 tb/tb_mux4_rr_scheduler.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_scheduler.sv
// ============================================================================
// Module   : mux4_rr_scheduler
// Brief    : Round-robin, slot-bounded scheduler driving a 4:1 mux select
//            and forwarding the granted channel's data as a registered stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux4_rr_scheduler #(
  parameter int DATA_W   = 1,
  parameter int SLOT_LEN = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            i_req,
  input  logic [4*DATA_W-1:0]   i_in,
  output logic                  o_s1,
  output logic                  o_s0,
  output logic [3:0]            o_gnt,
  output logic [DATA_W-1:0]     o_y,
  output logic                  o_y_valid
);

  localparam int                CNT_W       = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CNT_W-1:0]  C_SLOT_LAST = CNT_W'(SLOT_LEN - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t              r_state;
  logic [1:0]          r_ptr;
  logic [1:0]          r_cur;
  logic [3:0]          r_gnt;
  logic [CNT_W-1:0]    r_slot_cnt;
  logic [DATA_W-1:0]   r_y;
  logic                r_y_valid;

  logic                w_end;
  logic [1:0]          w_scan_base;
  logic [1:0]          w_idx;
  logic [1:0]          w_win;
  logic                w_found;
  logic [DATA_W-1:0]   w_data_cur;

  assign w_end       = (r_state == GRANT) && (!i_req[r_cur] || (r_slot_cnt == C_SLOT_LAST));
  // On a grant end the holder drops to lowest priority by scanning from cur+1.
  assign w_scan_base = (r_state == GRANT) ? r_cur + 2'd1 : r_ptr;
  assign w_data_cur  = i_in[r_cur*DATA_W +: DATA_W];

  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = w_scan_base + 2'(i);
      if (i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ptr      <= 2'd0;
      r_cur      <= 2'd0;
      r_gnt      <= 4'd0;
      r_slot_cnt <= '0;
      r_y        <= '0;
      r_y_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_y_valid <= 1'b0;
          if (w_found) begin
            r_state    <= GRANT;
            r_gnt      <= 4'(4'b0001 << w_win);
            r_cur      <= w_win;
            r_slot_cnt <= '0;
          end
        end
        GRANT: begin
          r_y       <= w_data_cur;
          r_y_valid <= i_req[r_cur];
          if (w_end) begin
            r_ptr <= r_cur + 2'd1;
            if (w_found) begin
              r_gnt      <= 4'(4'b0001 << w_win);
              r_cur      <= w_win;
              r_slot_cnt <= '0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 4'd0;
            end
          end else begin
            r_slot_cnt <= r_slot_cnt + CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_s1      = r_cur[1];
  assign o_s0      = r_cur[0];
  assign o_gnt     = r_gnt;
  assign o_y       = r_y;
  assign o_y_valid = r_y_valid;

endmodule

`default_nettype wire

// File: tb/tb_mux4_rr_scheduler.sv
// ============================================================================
// Module   : tb_mux4_rr_scheduler
// Brief    : Directed bench for mux4_rr_scheduler (SLOT_LEN=4 and SLOT_LEN=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux4_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic [3:0] req2 = 4'd0;
  logic [3:0] din = 4'b1101;

  logic       s1, s0, yv, y;
  logic [3:0] gnt;
  logic       s1b, s0b, yvb, yb;
  logic [3:0] gntb;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mux4_rr_scheduler #(.DATA_W(1), .SLOT_LEN(4)) u_dut (
    .clk(clk), .rst(rst), .i_req(req), .i_in(din),
    .o_s1(s1), .o_s0(s0), .o_gnt(gnt), .o_y(y), .o_y_valid(yv)
  );

  mux4_rr_scheduler #(.DATA_W(1), .SLOT_LEN(1)) u_dut1 (
    .clk(clk), .rst(rst), .i_req(req2), .i_in(din),
    .o_s1(s1b), .o_s0(s0b), .o_gnt(gntb), .o_y(yb), .o_y_valid(yvb)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Observed/expected packed as {gnt, s1, s0, y_valid, y}.
  task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] es,
                     input logic ev, input logic ey);
    logic [7:0] obs, exp;
    obs = {gnt, s1, s0, yv, y};
    exp = {eg, es, ev, ey};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed {gnt,sel,yv,y}=%b expected %b", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic [3:0] eg, input logic ev);
    logic [4:0] obs, exp;
    obs = {gntb, yvb};
    exp = {eg, ev};
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed {gnt,yv}=%b expected %b", tag, obs, exp);
  endtask

  initial begin
    logic [1:0] ch;
    logic       ey, ev;

    // 1. reset and idle
    tick(); tick();
    chk("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_hold", 4'b0000, 2'd0, 1'b0, 1'b0);
      chk1("idle_hold_s1", 4'b0000, 1'b0);
    end

    // 2. sole requester ch0, re-granted at slot expiry with no gap
    req = 4'b0001;
    tick();
    chk("ch0_grant", 4'b0001, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("ch0_stream", 4'b0001, 2'd0, 1'b1, 1'b1);
    end

    // 3. all requesting: 4-cycle slots in order ch0..ch3, ch0
    rst = 1'b1; tick(); rst = 1'b0;
    chk("reset_mid_grant0", 4'b0000, 2'd0, 1'b0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        tick();
        ch = 2'(k % 4);
        if (c == 0) begin
          ev = (k != 0);
          ey = (k == 0) ? 1'b0 : din[(k - 1) % 4];
        end else begin
          ev = 1'b1;
          ey = din[ch];
        end
        chk($sformatf("rr_k%0d_c%0d", k, c), 4'(4'b0001 << ch), ch, ev, ey);
      end
    end

    // 4. ch2 drops after 2 cycles with req=1001 -> ch3 next
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0100;
    tick();
    chk("ch2_grant", 4'b0100, 2'd2, 1'b0, 1'b0);
    tick();
    chk("ch2_stream", 4'b0100, 2'd2, 1'b1, 1'b1);
    req = 4'b1001;
    tick();
    chk("ch2_drop", 4'b1000, 2'd3, 1'b0, 1'b1);
    tick();
    chk("ch3_stream", 4'b1000, 2'd3, 1'b1, 1'b1);

    // ptr must return to 0 on reset (it was 3 here)
    rst = 1'b1; req = 4'b1111; tick(); rst = 1'b0;
    chk("reset_ptr", 4'b0000, 2'd0, 1'b0, 1'b0);
    tick();
    chk("ptr_after_reset", 4'b0001, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;

    // 5. SLOT_LEN=1 alternates ch0/ch2 every cycle
    req2 = 4'b0101;
    tick();
    chk1("sl1_first", 4'b0001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk1($sformatf("sl1_alt%0d", i), (i % 2 == 0) ? 4'b0100 : 4'b0001, 1'b1);
    end
    req2 = 4'b0000;

    // 6. reset during ch1 grant, then restart at ch1
    rst = 1'b1; tick(); rst = 1'b0;
    req = 4'b0010;
    tick();
    chk("ch1_grant", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    chk("ch1_stream", 4'b0010, 2'd1, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    chk("rst_in_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();
    chk("ch1_regrant", 4'b0010, 2'd1, 1'b0, 1'b0);
    tick();
    chk("ch1_restream", 4'b0010, 2'd1, 1'b1, 1'b0);

    // release to idle: grant ends, gnt clears, sel holds
    req = 4'b0000;
    tick();
    chk("to_idle", 4'b0000, 2'd1, 1'b0, 1'b0);
    tick();
    chk("idle_sel_hold", 4'b0000, 2'd1, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
